weapon_arsenal_ctrl: RTL and testbench

- Parametrised successor to the single-weapon fire FSM.
- Tracks NUM_WEAPONS weapons, each with its own ammo counter. Adds timed firing, cooldown, reload, empty-click and weapon selection.
- Driven by the Nexys4 fire switch and buttons.
- Outputs a one-hot weapon state, the active weapon index and its ammo to the HUD/SSD and sprite logic.

---
 rtl/weapon_pkg.sv | 35 +++
 rtl/weapon_ammo_bank.sv | 51 +++++
 rtl/weapon_arsenal_ctrl.sv | 162 ++++++++++++++++
 tb/tb_weapon_arsenal_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weapon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : weapon_pkg
// Brief    : State encodings and sizing helpers for the weapon arsenal.
// Revision : 1.0 - initial release
// ============================================================================
package weapon_pkg;

   localparam int STATE_W = 5;

   localparam logic [STATE_W-1:0] W_LOADED    = 5'b00001;
   localparam logic [STATE_W-1:0] W_FIRING    = 5'b00010;
   localparam logic [STATE_W-1:0] W_FIRE_IDLE = 5'b00100;
   localparam logic [STATE_W-1:0] W_RELOADING = 5'b01000;
   localparam logic [STATE_W-1:0] W_EMPTY     = 5'b10000;

   typedef enum logic [STATE_W-1:0] {
      ST_LOADED    = W_LOADED,
      ST_FIRING    = W_FIRING,
      ST_FIRE_IDLE = W_FIRE_IDLE,
      ST_RELOADING = W_RELOADING,
      ST_EMPTY     = W_EMPTY
   } weapon_state_e;

   // Width needed to hold the largest of the three phase lengths.
   function automatic int timer_width(input int fire_c, input int cool_c, input int reload_c);
      int m;
      m = fire_c;
      if (cool_c > m) m = cool_c;
      if (reload_c > m) m = reload_c;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/weapon_ammo_bank.sv
`default_nettype none
// ============================================================================
// Module   : weapon_ammo_bank
// Brief    : Per-weapon ammo registers with decrement/refill on one slot.
// Revision : 1.0 - initial release
// ============================================================================
module weapon_ammo_bank #(
   parameter int NUM_WEAPONS = 4,
   parameter int AMMO_W      = 6,
   parameter int MAX_AMMO    = 30,
   parameter int SEL_W       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_en,
   input  logic              refill_en,
   input  logic [SEL_W-1:0]  idx,
   output logic [AMMO_W-1:0] rd_ammo,
   input  logic [SEL_W-1:0]  peek_idx,
   output logic [AMMO_W-1:0] peek_ammo
);

   logic [AMMO_W-1:0] ammo_q [NUM_WEAPONS];
   logic [AMMO_W-1:0] ammo_d [NUM_WEAPONS];

   always_comb begin
      for (int i = 0; i < NUM_WEAPONS; i++) begin
         ammo_d[i] = ammo_q[i];
         if (idx == SEL_W'(i)) begin
            if (refill_en) begin
               ammo_d[i] = AMMO_W'(MAX_AMMO);
            end else if (dec_en && (ammo_q[i] != '0)) begin
               ammo_d[i] = ammo_q[i] - AMMO_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_WEAPONS; i++) begin
         if (rst) ammo_q[i] <= AMMO_W'(MAX_AMMO);
         else     ammo_q[i] <= ammo_d[i];
      end
   end

   // Second read port lets a select decide LOADED/EMPTY for the target slot.
   assign rd_ammo   = ammo_q[idx];
   assign peek_ammo = ammo_q[peek_idx];

endmodule
`default_nettype wire

// File: rtl/weapon_arsenal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weapon_arsenal_ctrl
// Brief    : Multi-weapon fire/cooldown/reload controller with ammo tracking.
// Revision : 1.0 - initial release
// ============================================================================
module weapon_arsenal_ctrl
   import weapon_pkg::*;
#(
   parameter  int NUM_WEAPONS     = 4,
   parameter  int AMMO_W          = 6,
   parameter  int MAX_AMMO        = 30,
   parameter  int FIRE_CYCLES     = 4,
   parameter  int COOLDOWN_CYCLES = 8,
   parameter  int RELOAD_CYCLES   = 16,
   localparam int SEL_W           = $clog2(NUM_WEAPONS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_switch,
   input  logic               sel_valid,
   input  logic [SEL_W-1:0]   sel_idx,
   input  logic               reload_req,
   output logic [STATE_W-1:0] weapon_state,
   output logic [SEL_W-1:0]   active_weapon,
   output logic [AMMO_W-1:0]  ammo_count,
   output logic               fire_pulse,
   output logic               empty_click
);

   localparam int TIMER_W = timer_width(FIRE_CYCLES, COOLDOWN_CYCLES, RELOAD_CYCLES);
   localparam int NSEL    = 2 ** SEL_W;
   localparam logic [NSEL-1:0] SEL_VALID = NSEL'((1 << NUM_WEAPONS) - 1);

   weapon_state_e      state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [SEL_W-1:0]   active_q, active_d;
   logic               sw_q;
   logic               fire_q, fire_d;
   logic               click_q, click_d;

   logic               dec_en, refill_en;
   logic [AMMO_W-1:0]  peek_ammo;
   logic               trig_rise, sel_ok, cool_done, have_ammo;

   assign trig_rise = in_switch & ~sw_q;
   assign sel_ok    = SEL_VALID[sel_idx];
   assign cool_done = timer_q >= TIMER_W'(COOLDOWN_CYCLES - 1);
   assign have_ammo = ammo_count != '0;

   weapon_ammo_bank #(
      .NUM_WEAPONS (NUM_WEAPONS),
      .AMMO_W      (AMMO_W),
      .MAX_AMMO    (MAX_AMMO),
      .SEL_W       (SEL_W)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .dec_en    (dec_en),
      .refill_en (refill_en),
      .idx       (active_q),
      .rd_ammo   (ammo_count),
      .peek_idx  (sel_idx),
      .peek_ammo (peek_ammo)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      active_d  = active_q;
      fire_d    = 1'b0;
      click_d   = 1'b0;
      dec_en    = 1'b0;
      refill_en = 1'b0;
      case (state_q)
         ST_LOADED: begin
            // An out-of-range select still wins priority and is then dropped.
            if (sel_valid) begin
               if (sel_ok) begin
                  active_d = sel_idx;
                  state_d  = (peek_ammo != '0) ? ST_LOADED : ST_EMPTY;
               end
            end else if (reload_req) begin
               if (ammo_count != AMMO_W'(MAX_AMMO)) begin
                  state_d = ST_RELOADING;
                  timer_d = '0;
               end
            end else if (trig_rise) begin
               state_d = ST_FIRING;
               timer_d = '0;
               dec_en  = 1'b1;
               fire_d  = 1'b1;
            end
         end
         ST_FIRING: begin
            if (timer_q == TIMER_W'(FIRE_CYCLES - 1)) begin
               state_d = ST_FIRE_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_FIRE_IDLE: begin
            if (cool_done && !in_switch) begin
               state_d = have_ammo ? ST_LOADED : ST_EMPTY;
            end else if (!cool_done) begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_RELOADING: begin
            if (timer_q == TIMER_W'(RELOAD_CYCLES - 1)) begin
               state_d   = ST_LOADED;
               refill_en = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_EMPTY: begin
            if (sel_valid) begin
               if (sel_ok) begin
                  active_d = sel_idx;
                  state_d  = (peek_ammo != '0) ? ST_LOADED : ST_EMPTY;
               end
            end else if (reload_req) begin
               state_d = ST_RELOADING;
               timer_d = '0;
            end else if (trig_rise) begin
               click_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_LOADED;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOADED;
         timer_q  <= '0;
         active_q <= '0;
         sw_q     <= 1'b0;
         fire_q   <= 1'b0;
         click_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         active_q <= active_d;
         sw_q     <= in_switch;
         fire_q   <= fire_d;
         click_q  <= click_d;
      end
   end

   assign weapon_state  = state_q;
   assign active_weapon = active_q;
   assign fire_pulse    = fire_q;
   assign empty_click   = click_q;

endmodule
`default_nettype wire

// File: tb/tb_weapon_arsenal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weapon_arsenal_ctrl
// Brief    : Directed + random check of weapon_arsenal_ctrl against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weapon_arsenal_ctrl;

   localparam int NW   = 5;
   localparam int AW   = 6;
   localparam int MAXA = 30;
   localparam int FC   = 4;
   localparam int CC   = 8;
   localparam int RC   = 16;
   localparam int SW   = 3;

   localparam int M_LOADED    = 1;
   localparam int M_FIRING    = 2;
   localparam int M_FIRE_IDLE = 4;
   localparam int M_RELOADING = 8;
   localparam int M_EMPTY     = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_switch = 1'b0;
   logic          sel_valid = 1'b0;
   logic [SW-1:0] sel_idx = '0;
   logic          reload_req = 1'b0;
   logic [4:0]    weapon_state;
   logic [SW-1:0] active_weapon;
   logic [AW-1:0] ammo_count;
   logic          fire_pulse;
   logic          empty_click;

   weapon_arsenal_ctrl #(
      .NUM_WEAPONS     (NW),
      .AMMO_W          (AW),
      .MAX_AMMO        (MAXA),
      .FIRE_CYCLES     (FC),
      .COOLDOWN_CYCLES (CC),
      .RELOAD_CYCLES   (RC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_switch     (in_switch),
      .sel_valid     (sel_valid),
      .sel_idx       (sel_idx),
      .reload_req    (reload_req),
      .weapon_state  (weapon_state),
      .active_weapon (active_weapon),
      .ammo_count    (ammo_count),
      .fire_pulse    (fire_pulse),
      .empty_click   (empty_click)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: phase counters rather than a timer register.
   int m_state, m_active, m_left, m_idle;
   int m_ammo [NW];
   bit m_sw, m_fire, m_click;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit sw, input bit sv, input int si, input bit rl, input bit r);
      bit rise;
      rise    = sw && !m_sw;
      m_sw    = sw;
      m_fire  = 0;
      m_click = 0;
      if (r) begin
         m_state  = M_LOADED;
         m_active = 0;
         m_sw     = 0;
         foreach (m_ammo[k]) m_ammo[k] = MAXA;
         return;
      end
      case (m_state)
         M_LOADED, M_EMPTY: begin
            if (sv) begin
               if (si < NW) begin
                  m_active = si;
                  m_state  = (m_ammo[si] > 0) ? M_LOADED : M_EMPTY;
               end
            end else if (rl) begin
               if (m_state == M_EMPTY || m_ammo[m_active] < MAXA) begin
                  m_state = M_RELOADING;
                  m_left  = RC;
               end
            end else if (rise) begin
               if (m_state == M_EMPTY) begin
                  m_click = 1;
               end else begin
                  m_state = M_FIRING;
                  m_left  = FC;
                  m_fire  = 1;
                  if (m_ammo[m_active] > 0) m_ammo[m_active]--;
               end
            end
         end
         M_FIRING: begin
            m_left--;
            if (m_left == 0) begin
               m_state = M_FIRE_IDLE;
               m_idle  = 0;
            end
         end
         M_FIRE_IDLE: begin
            m_idle++;
            if (m_idle >= CC && !sw) m_state = (m_ammo[m_active] > 0) ? M_LOADED : M_EMPTY;
         end
         M_RELOADING: begin
            m_left--;
            if (m_left == 0) begin
               m_ammo[m_active] = MAXA;
               m_state = M_LOADED;
            end
         end
         default: ;
      endcase
   endtask

   task automatic cyc(input bit sw, input bit sv, input int si, input bit rl, input bit r);
      in_switch  = sw;
      sel_valid  = sv;
      sel_idx    = SW'(si);
      reload_req = rl;
      rst        = r;
      @(posedge clk);
      model_step(sw, sv, si, rl, r);
      #1;
      chk("state",  32'(weapon_state),  32'(m_state));
      chk("active", 32'(active_weapon), 32'(m_active));
      chk("ammo",   32'(ammo_count),    32'(m_ammo[m_active]));
      chk("fire",   32'(fire_pulse),    32'(m_fire));
      chk("click",  32'(empty_click),   32'(m_click));
   endtask

   // One tap of the trigger followed by enough idle cycles to finish cooldown.
   task automatic shot();
      cyc(1, 0, 0, 0, 0);
      repeat (FC + CC + 1) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      int nfire;
      bit sw;

      cyc(0, 0, 0, 0, 1);
      chk("rst_state", 32'(weapon_state), 1);
      chk("rst_ammo", 32'(ammo_count), 30);
      chk("rst_active", 32'(active_weapon), 0);
      repeat (8) cyc(0, 0, 0, 0, 0);

      // Single shot timing
      cyc(1, 0, 0, 0, 0);
      chk("t1_firing", 32'(weapon_state), 2);
      chk("t1_pulse", 32'(fire_pulse), 1);
      chk("t1_ammo", 32'(ammo_count), 29);
      cyc(0, 0, 0, 0, 0);
      chk("t1_pulse_once", 32'(fire_pulse), 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      chk("t1_idle", 32'(weapon_state), 4);
      repeat (7) cyc(0, 0, 0, 0, 0);
      chk("t1_cool_min", 32'(weapon_state), 4);
      cyc(0, 0, 0, 0, 0);
      chk("t1_loaded", 32'(weapon_state), 1);

      // Held trigger: no auto-fire, stuck in FIRE_IDLE until release
      cyc(1, 0, 0, 0, 0);
      nfire = 0;
      repeat (FC + 40) begin
         cyc(1, 0, 0, 0, 0);
         nfire += int'(fire_pulse);
      end
      chk("hold_nofire", nfire, 0);
      chk("hold_idle", 32'(weapon_state), 4);
      cyc(0, 0, 0, 0, 0);
      chk("hold_release", 32'(weapon_state), 1);

      // Drain weapon 0, empty click, reload
      while (m_ammo[0] > 0) shot();
      chk("drain_empty", 32'(weapon_state), 16);
      chk("drain_ammo", 32'(ammo_count), 0);
      cyc(1, 0, 0, 0, 0);
      chk("click_hi", 32'(empty_click), 1);
      chk("click_ammo", 32'(ammo_count), 0);
      cyc(0, 0, 0, 0, 0);
      chk("click_lo", 32'(empty_click), 0);
      cyc(0, 0, 0, 1, 0);
      chk("reload_enter", 32'(weapon_state), 8);
      repeat (RC - 1) cyc(0, 0, 0, 0, 0);
      chk("reload_last", 32'(weapon_state), 8);
      cyc(0, 0, 0, 0, 0);
      chk("reload_done", 32'(weapon_state), 1);
      chk("reload_ammo", 32'(ammo_count), 30);

      // Per-slot ammo retention across selects
      shot();
      shot();
      cyc(0, 1, 2, 0, 0);
      shot();
      chk("slot2_ammo", 32'(ammo_count), 29);
      cyc(0, 1, 0, 0, 0);
      chk("slot0_ammo", 32'(ammo_count), 28);

      // Out-of-range select is dropped
      cyc(0, 1, 5, 0, 0);
      chk("sel_oob", 32'(active_weapon), 0);

      // Select beats reload in the same cycle
      cyc(0, 1, 2, 1, 0);
      chk("sel_prio_idx", 32'(active_weapon), 2);
      chk("sel_prio_state", 32'(weapon_state), 1);

      // Reset in the middle of a reload
      cyc(0, 1, 1, 0, 0);
      repeat (20) shot();
      chk("w1_ammo10", 32'(ammo_count), 10);
      cyc(0, 0, 0, 1, 0);
      repeat (6) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("midrst_state", 32'(weapon_state), 1);
      chk("midrst_active", 32'(active_weapon), 0);
      for (int w = 0; w < NW; w++) begin
         cyc(0, 1, w, 0, 0);
         chk("midrst_slot", 32'(ammo_count), 30);
      end

      // Random traffic
      sw = 0;
      repeat (3000) begin
         if ($urandom_range(0, 5) == 0) sw = ~sw;
         cyc(sw, $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
